// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with an optional 2-entry skid buffer.
// Occupancy is the state encoding; flush empties the stage and reloads CLEAR_VAL.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter bit               SKID      = 1'b1,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  // With the skid buffer, ready comes straight from a flop; without it, ready looks through to out_ready.
  assign in_ready  = SKID ? rdy_q : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
          main_d  = CLEAR_VAL;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = CLEAR_VAL;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = CLEAR_VAL;
        skid_d  = CLEAR_VAL;
      end
    endcase
    // Flush drops everything, including a beat accepted this cycle.
    if (flush) begin
      state_d = EMPTY;
      main_d  = CLEAR_VAL;
      skid_d  = CLEAR_VAL;
    end
    rdy_d = (state_d != FULL);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= EMPTY;
      main_q  <= CLEAR_VAL;
      skid_q  <= CLEAR_VAL;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1/WIDTH=32 and SKID=0/WIDTH=8 instances driven in lockstep
// and compared every cycle against queue-based models of the stage.
module tb_pipe_stage_reg;

  logic        CLK = 1'b0;
  logic        nRST, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [7:0]  in_data0;

  logic        in_ready1, out_valid1;
  logic [31:0] out_data1;
  logic [1:0]  occ1;
  logic        in_ready0, out_valid0;
  logic [7:0]  out_data0;
  logic [1:0]  occ0;

  int checks   = 0;
  int failures = 0;
  bit known    = 1'b0;

  logic [31:0] q1[$];
  logic [7:0]  q0[$];

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .CLEAR_VAL(32'h0)) dut1 (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1)
  );

  pipe_stage_reg #(.WIDTH(8), .SKID(1'b0), .CLEAR_VAL(8'h0)) dut0 (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, compare against the model, then advance the model at the rising edge.
  task automatic step(input logic rn, input logic fl, input logic iv,
                      input logic [31:0] id, input logic ordy);
    bit ifire1, ofire1, ifire0, ofire0;
    @(negedge CLK);
    nRST = rn; flush = fl; in_valid = iv; in_data = id; in_data0 = id[7:0]; out_ready = ordy;
    #1;
    if (known) begin
      check_eq("s1_out_valid", {31'b0, out_valid1}, {31'b0, q1.size() > 0});
      check_eq("s1_out_data",  out_data1, (q1.size() > 0) ? q1[0] : 32'h0);
      check_eq("s1_occupancy", {30'b0, occ1}, q1.size());
      check_eq("s1_in_ready",  {31'b0, in_ready1}, {31'b0, q1.size() < 2});
      check_eq("s0_out_valid", {31'b0, out_valid0}, {31'b0, q0.size() > 0});
      check_eq("s0_out_data",  {24'b0, out_data0}, {24'b0, (q0.size() > 0) ? q0[0] : 8'h0});
      check_eq("s0_occupancy", {30'b0, occ0}, q0.size());
      check_eq("s0_in_ready",  {31'b0, in_ready0}, {31'b0, (q0.size() == 0) || ordy});
    end
    ofire1 = (q1.size() > 0) && ordy;
    ifire1 = iv && (q1.size() < 2);
    ofire0 = (q0.size() > 0) && ordy;
    ifire0 = iv && ((q0.size() == 0) || ordy);
    @(posedge CLK);
    if (!rn) begin
      q1.delete();
      q0.delete();
      known = 1'b1;
    end else begin
      if (ofire1) void'(q1.pop_front());
      if (ifire1 && !fl) q1.push_back(id);
      if (fl) q1.delete();
      if (ofire0) void'(q0.pop_front());
      if (ifire0 && !fl) q0.push_back(id[7:0]);
      if (fl) q0.delete();
    end
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_data0 = '0; out_ready = 1'b0;

    // Reset held two cycles with in_valid high
    step(1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hBEEF, 1'b0);
    #1;
    check_eq("rst_out_valid", {31'b0, out_valid1}, 32'd0);
    check_eq("rst_out_data", out_data1, 32'h0);
    check_eq("rst_occupancy", {30'b0, occ1}, 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready1}, 32'd1);

    // Streaming
    step(1'b1, 1'b0, 1'b1, 32'h1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h2, 1'b1);
    #1 check_eq("stream_data2", out_data1, 32'h2);
    step(1'b1, 1'b0, 1'b1, 32'h3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Backpressure into the skid entry, then drain
    step(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
    #1;
    check_eq("full_occupancy", {30'b0, occ1}, 32'd2);
    check_eq("full_in_ready", {31'b0, in_ready1}, 32'd0);
    check_eq("full_data", out_data1, 32'hA);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    #1 check_eq("drain_first", out_data1, 32'hB);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Flush while FULL with a competing beat
    step(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'hC, 1'b0);
    #1;
    check_eq("flush_full_valid", {31'b0, out_valid1}, 32'd0);
    check_eq("flush_full_data", out_data1, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush coincident with out_fire, then a fresh push
    step(1'b1, 1'b0, 1'b1, 32'h5, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h6, 1'b0);
    #1 check_eq("post_flush_push", out_data1, 32'h6);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Pass-through replace on the SKID=0 instance, then stall
    step(1'b1, 1'b0, 1'b1, 32'h11, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h22, 1'b1);
    #1 check_eq("s0_replace", {24'b0, out_data0}, 32'h22);
    step(1'b1, 1'b0, 1'b1, 32'h33, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 70), $urandom, ($urandom_range(0, 99) < 60));
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register: the generalised successor of the fixed-field stage latches (IF/ID … MEM/WB) with flush/write-enable.
- Carries an opaque WIDTH-bit payload. The stage packs its own fields into the payload.
- Replaces write-enable stalling with a valid/ready handshake. An optional 2-entry skid buffer keeps in_ready registered (no combinational ready path).
- Flush clears all held entries to a parametrised clear value.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CLEAR_VAL, '0, payload value loaded on reset and on flush (WIDTH bits).

Ports:
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  synchronous active-low reset
- flush  in  1  discard all held entries and any beat accepted this cycle
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  out_data holds a live beat
- out_ready  in  1  downstream accepts the beat this cycle
- out_data  out  WIDTH  head payload (main register)
- occupancy  out  2  entries held: 0, 1, or 2 (2 only when SKID=1)

Behaviour:
- Reset and clock: one clock domain. nRST is synchronous, active-low, sampled on the CLK rising edge and takes priority over everything.
- Reset values: state EMPTY; out_valid=0; out_data=CLEAR_VAL; skid register=CLEAR_VAL; occupancy=0; in_ready=1 after the reset edge.
- Handshake definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - Payload must be held stable by the producer while in_valid=1 and in_ready=0. The block does not check this.
- Latency and throughput: 1 cycle. A beat accepted on edge N is visible on out_data/out_valid after edge N. Sustains 1 beat/cycle when out_ready=1.
- Ordering: strictly FIFO. No beat is duplicated or reordered.
- SKID=1 state machine (occupancy encodes state):
  - EMPTY(0): out_valid=0, in_ready=1.
    - in_fire -> ONE, main<=in_data.
  - ONE(1): out_valid=1, in_ready=1.
    - in_fire & out_fire -> ONE, main<=in_data.
    - in_fire & !out_fire -> FULL, skid<=in_data.
    - !in_fire & out_fire -> EMPTY.
    - neither -> hold.
  - FULL(2): out_valid=1, in_ready=0.
    - out_fire -> ONE, main<=skid, skid<=CLEAR_VAL.
    - else hold.
  - in_ready is a registered function of state only; no combinational path from out_ready.
- SKID=0:
  - Single main register; occupancy ∈ {0,1}.
  - in_ready = !out_valid | out_ready (combinational).
  - in_fire loads main and sets out_valid.
  - out_fire without in_fire clears out_valid.
- Main register in EMPTY: always reads as CLEAR_VAL. It is loaded with CLEAR_VAL whenever the state transitions to EMPTY.
- Flush (priority below reset, above handshake):
  - Next state EMPTY; main and skid <= CLEAR_VAL; out_valid=0 after the edge.
  - A beat with in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as delivered, because the downstream consumed it combinationally.
  - in_ready keeps its state-derived value during flush. After flush, in_ready=1.
- Back-to-back flushes: state stays EMPTY.
- Flush and reset asserted together: reset wins. The result is identical either way.
- Reset mid-transfer: all held beats are lost. There is no partial-beat state.
- Occupancy never exceeds 1 when SKID=0, and never exceeds 2 when SKID=1.
- No arithmetic on the payload. occupancy is the 2-bit state encoding, not a counter that can wrap.

Test Plan:
- Reset (SKID=1, WIDTH=32): hold nRST=0 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, occupancy=0, in_ready=1 after the first reset edge.
- Streaming: out_ready=1, in_data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each; occupancy stays 1; in_ready stays 1.
- Backpressure into skid: out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0, out_data=0xA. Then out_ready=1 for 2 cycles -> 0xA then 0xB delivered, occupancy 1 then 0, in_ready=1 after the first pop.
- Flush while FULL (0xA, 0xB held): flush=1 with in_valid=1, in_data=0xC -> after the edge out_valid=0, occupancy=0, out_data=CLEAR_VAL. 0xC is never output.
- Flush coincident with out_fire in ONE holding 0x5 -> 0x5 counted delivered on that cycle; next cycle EMPTY; a subsequent push of 0x6 appears after 1 cycle.
- SKID=0, WIDTH=8: out_valid=1 holding 0x11, out_ready=1 and in_valid=1 with 0x22 in the same cycle -> in_ready=1 combinationally; 0x22 on out_data next cycle. With out_ready=0 -> in_ready=0 and 0x11 held.
